// File: rtl/fft_ser_pkg.sv
// Shared sizes, state encodings and sample types for the FFT output serializer.
package fft_ser_pkg;

  localparam int unsigned DATA_W = 13;
  localparam int unsigned LANES  = 16;
  localparam int unsigned NPT    = 512;
  localparam int unsigned BEATS  = NPT / LANES;
  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned ADDR_W = $clog2(NPT);
  localparam int unsigned CNT_W  = 8;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_st_e;
  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} ser_state_e;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef sample_t [LANES-1:0]      beat_t;
  typedef sample_t [NPT-1:0]        frame_t;

endpackage

// File: rtl/fft_ser_bank.sv
// One frame store of the ping-pong buffer: whole-frame parallel write, 16-lane slice read.
module fft_ser_bank
  import fft_ser_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  frame_t            wr_re,
  input  frame_t            wr_im,
  input  logic [BEAT_W-1:0] rd_beat,
  output beat_t             rd_re_c,
  output beat_t             rd_im_c
);

  frame_t            mem_re;
  frame_t            mem_im;
  logic [ADDR_W-1:0] base_c;

  // Frame capture; contents are qualified by the owner's bank status, so no reset is needed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_re <= wr_re;
      mem_im <= wr_im;
    end
  end

  // Slice of LANES consecutive bins starting at rd_beat*LANES.
  always_comb begin
    base_c  = {rd_beat, {LANE_W{1'b0}}};
    rd_re_c = mem_re[base_c +: LANES];
    rd_im_c = mem_im[base_c +: LANES];
  end

endmodule

// File: rtl/fft_out_serializer.sv
// FFT output serializer: captures 512-bin frames into a ping-pong buffer and streams each
// frame as 32 beats of 16 bins under valid/ready. Optional macro FFT_SER_OVF_CNT_EN adds a
// saturating 8-bit dropped-frame counter on port ovf_cnt.
module fft_out_serializer
  import fft_ser_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              valid_in,
  input  frame_t            din_re,
  input  frame_t            din_im,
  input  logic              ready_out,
  output logic              valid_out,
  output beat_t             dout_re,
  output beat_t             dout_im,
  output logic [BEAT_W-1:0] beat_idx,
  output logic              last_out,
  output logic              frame_ovf
`ifdef FFT_SER_OVF_CNT_EN
  ,
  output logic [CNT_W-1:0]  ovf_cnt
`endif
);

  ser_state_e        state, state_n;
  bank_st_e          bank_st   [2];
  bank_st_e          bank_st_n [2];
  logic              rd_ptr, rd_ptr_n;
  logic              wr_ptr, wr_ptr_n;
  logic [BEAT_W-1:0] beat_n;
  logic              valid_n, last_n, frame_ovf_n;
  beat_t             dout_re_n, dout_im_n;
  logic [BEAT_W-1:0] rd_beat_c [2];
  beat_t             bank_re_c [2];
  beat_t             bank_im_c [2];
  logic [1:0]        we_c;
  logic              xfer_c, cap_c, drop_c;
  logic [BEAT_W-1:0] nxt_beat_c;

  fft_ser_bank u_ping (
    .clk     (clk),
    .we      (we_c[0]),
    .wr_re   (din_re),
    .wr_im   (din_im),
    .rd_beat (rd_beat_c[0]),
    .rd_re_c (bank_re_c[0]),
    .rd_im_c (bank_im_c[0])
  );

  fft_ser_bank u_pong (
    .clk     (clk),
    .we      (we_c[1]),
    .wr_re   (din_re),
    .wr_im   (din_im),
    .rd_beat (rd_beat_c[1]),
    .rd_re_c (bank_re_c[1]),
    .rd_im_c (bank_im_c[1])
  );

  // Read slice each bank would present next: the active bank looks one beat ahead,
  // the idle bank (or both, when IDLE) presents beat 0 for an immediate start.
  always_comb begin
    rd_beat_c[0] = '0;
    rd_beat_c[1] = '0;
    if (state == STREAM) begin
      rd_beat_c[rd_ptr] = BEAT_W'(beat_idx + 1'b1);
    end
  end

  // Next-state, buffer bookkeeping and registered-output values.
  always_comb begin
    state_n      = state;
    bank_st_n[0] = bank_st[0];
    bank_st_n[1] = bank_st[1];
    rd_ptr_n     = rd_ptr;
    wr_ptr_n     = wr_ptr;
    beat_n       = beat_idx;
    valid_n      = valid_out;
    last_n       = last_out;
    dout_re_n    = dout_re;
    dout_im_n    = dout_im;
    frame_ovf_n  = frame_ovf;
    we_c         = 2'b00;

    xfer_c     = valid_out && ready_out;
    cap_c      = valid_in && (bank_st[wr_ptr] == EMPTY);
    drop_c     = valid_in && (bank_st[wr_ptr] == FULL);
    nxt_beat_c = BEAT_W'(beat_idx + 1'b1);

    case (state)
      IDLE: begin
        if (bank_st[rd_ptr] == FULL) begin
          state_n   = STREAM;
          valid_n   = 1'b1;
          beat_n    = '0;
          last_n    = 1'b0;
          dout_re_n = bank_re_c[rd_ptr];
          dout_im_n = bank_im_c[rd_ptr];
        end
      end
      STREAM: begin
        if (xfer_c) begin
          if (beat_idx == BEAT_W'(BEATS - 1)) begin
            bank_st_n[rd_ptr] = EMPTY;
            rd_ptr_n          = ~rd_ptr;
            beat_n            = '0;
            last_n            = 1'b0;
            if (bank_st[~rd_ptr] == FULL) begin
              dout_re_n = bank_re_c[~rd_ptr];
              dout_im_n = bank_im_c[~rd_ptr];
            end else begin
              state_n = IDLE;
              valid_n = 1'b0;
            end
          end else begin
            beat_n    = nxt_beat_c;
            last_n    = (nxt_beat_c == BEAT_W'(BEATS - 1));
            dout_re_n = bank_re_c[rd_ptr];
            dout_im_n = bank_im_c[rd_ptr];
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // A capture never targets the bank being released: it needs an EMPTY bank.
    if (cap_c) begin
      we_c[wr_ptr]      = 1'b1;
      bank_st_n[wr_ptr] = FULL;
      wr_ptr_n          = ~wr_ptr;
    end
    if (drop_c) begin
      frame_ovf_n = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      beat_idx   <= '0;
      valid_out  <= 1'b0;
      last_out   <= 1'b0;
      dout_re    <= '0;
      dout_im    <= '0;
      frame_ovf  <= 1'b0;
    end else begin
      state      <= state_n;
      bank_st[0] <= bank_st_n[0];
      bank_st[1] <= bank_st_n[1];
      rd_ptr     <= rd_ptr_n;
      wr_ptr     <= wr_ptr_n;
      beat_idx   <= beat_n;
      valid_out  <= valid_n;
      last_out   <= last_n;
      dout_re    <= dout_re_n;
      dout_im    <= dout_im_n;
      frame_ovf  <= frame_ovf_n;
    end
  end

`ifdef FFT_SER_OVF_CNT_EN
  logic [CNT_W-1:0] ovf_cnt_n;

  // Saturating count of dropped frames.
  always_comb begin
    ovf_cnt_n = ovf_cnt;
    if (drop_c && (ovf_cnt != '1)) begin
      ovf_cnt_n = CNT_W'(ovf_cnt + 1'b1);
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_cnt <= '0;
    end else begin
      ovf_cnt <= ovf_cnt_n;
    end
  end
`endif

endmodule
